ssd_scan_controller: RTL

- Time-multiplexes the shared 4-digit seven-segment display bus (one segment bus, four active-low digit enables) across four BCD digit sources.
- Generates its own scan timing from the single system clock with an internal prescaler counter; no derived clocks.
- Inserts a blanking interval between digit slots to prevent ghosting.
- Sits between the counter/timer datapath (stopwatch, clock display) and the board display pins.

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/ssd_decoder.sv | 27 ++
 rtl/ssd_scan_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and segment constants for the seven-segment scan controller
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  // Full 8-bit bus values {a,b,c,d,e,f,g,dp}, active-low
  localparam logic [7:0] SSD_OFF  = 8'hFF;
  localparam logic [7:0] SSD_DASH = 8'hFD;

  localparam logic [3:0] DIGITS_OFF = 4'b1111;

  // Seven-segment patterns {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

endpackage

// File: rtl/ssd_decoder.sv
// rtl/ssd_decoder.sv - BCD nibble to active-low seven-segment pattern
module ssd_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Non-BCD nibbles (10-15) render as a dash so bad data is visible
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - 4-digit seven-segment scan with blanking; SSD_SCAN_DECIMAL_POINT_EN adds dp_mask
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV           = 100_000,
  parameter int SCAN_DIV_BIT_WIDTH = 17,
  parameter int BLANK_CYCLES       = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits,
`ifdef SSD_SCAN_DECIMAL_POINT_EN
  input  logic [3:0]  dp_mask,
`endif
  input  logic        lz_suppress,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  segs,
  output logic [1:0]  scan_idx,
  output logic        frame_done
);

  localparam logic [SCAN_DIV_BIT_WIDTH-1:0] BLANK_LAST = SCAN_DIV_BIT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [SCAN_DIV_BIT_WIDTH-1:0] SLOT_LAST  = SCAN_DIV_BIT_WIDTH'(SCAN_DIV - 1);
  localparam logic [SCAN_DIV_BIT_WIDTH-1:0] PRE_ONE    = SCAN_DIV_BIT_WIDTH'(1);

  scan_state_e                   state, state_next;
  logic [SCAN_DIV_BIT_WIDTH-1:0] prescaler, prescaler_next;
  logic [1:0]                    scan_idx_next;
  logic [3:0]                    ssd_ctl_next;
  logic [7:0]                    segs_next;
  logic                          frame_done_next;

  logic [3:0] nibble;
  logic [6:0] seg7;
  logic       suppress;
  logic       dp_on;
  logic [3:0] digit_en;

  assign nibble   = digits[{scan_idx, 2'b00} +: 4];
  assign digit_en = ~(4'b0001 << scan_idx);

`ifdef SSD_SCAN_DECIMAL_POINT_EN
  assign dp_on = dp_mask[scan_idx];
`else
  assign dp_on = 1'b0;
`endif

  ssd_decoder u_decoder (
    .nibble (nibble),
    .seg    (seg7)
  );

  // A digit is a leading zero when it and every higher digit are zero; digit0 always shows
  always_comb begin
    suppress = 1'b0;
    case (scan_idx)
      2'd1:    suppress = lz_suppress && (digits[15:4]  == 12'd0);
      2'd2:    suppress = lz_suppress && (digits[15:8]  == 8'd0);
      2'd3:    suppress = lz_suppress && (digits[15:12] == 4'd0);
      default: suppress = 1'b0;
    endcase
  end

  // Next state plus next registered outputs; segs/ssd_ctl hold the latched slot values through DRIVE
  always_comb begin
    state_next      = state;
    prescaler_next  = prescaler;
    scan_idx_next   = scan_idx;
    ssd_ctl_next    = ssd_ctl;
    segs_next       = segs;
    frame_done_next = 1'b0;

    if (!enable) begin
      state_next     = IDLE;
      prescaler_next = '0;
      scan_idx_next  = 2'd0;
      ssd_ctl_next   = DIGITS_OFF;
      segs_next      = SSD_OFF;
    end else begin
      case (state)
        IDLE: begin
          state_next     = BLANK;
          prescaler_next = '0;
          scan_idx_next  = 2'd0;
          ssd_ctl_next   = DIGITS_OFF;
          segs_next      = SSD_OFF;
        end
        BLANK: begin
          ssd_ctl_next   = DIGITS_OFF;
          segs_next      = SSD_OFF;
          prescaler_next = prescaler + PRE_ONE;
          if (prescaler == BLANK_LAST) begin
            state_next = DRIVE;
            if (suppress) begin
              ssd_ctl_next = dp_on ? digit_en : DIGITS_OFF;
              segs_next    = {7'b1111111, ~dp_on};
            end else begin
              ssd_ctl_next = digit_en;
              segs_next    = {seg7, ~dp_on};
            end
          end
        end
        DRIVE: begin
          if (prescaler == SLOT_LAST) begin
            state_next      = BLANK;
            prescaler_next  = '0;
            scan_idx_next   = scan_idx + 2'd1;
            ssd_ctl_next    = DIGITS_OFF;
            segs_next       = SSD_OFF;
            frame_done_next = (scan_idx == 2'd3);
          end else begin
            prescaler_next = prescaler + PRE_ONE;
          end
        end
        default: begin
          state_next     = IDLE;
          prescaler_next = '0;
          scan_idx_next  = 2'd0;
          ssd_ctl_next   = DIGITS_OFF;
          segs_next      = SSD_OFF;
        end
      endcase
    end
  end

  // State and all outputs register together so the pins never glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      scan_idx   <= 2'd0;
      ssd_ctl    <= DIGITS_OFF;
      segs       <= SSD_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      prescaler  <= prescaler_next;
      scan_idx   <= scan_idx_next;
      ssd_ctl    <= ssd_ctl_next;
      segs       <= segs_next;
      frame_done <= frame_done_next;
    end
  end

endmodule
